// File: rtl/inst_mem_pipe_pkg.sv
// Shared defaults for the instruction memory: bus widths, default depth and
// the NOP word handed back on a faulted fetch.
package inst_mem_pipe_pkg;

    localparam int INST_ADDR_W   = 32;
    localparam int INST_DATA_W   = 32;
    localparam int MEM_INST_SIZE = 1024;
    localparam int RD_LAT_MAX    = 4;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef logic [INST_ADDR_W-1:0] inst_addr_t;
    typedef logic [INST_DATA_W-1:0] inst_t;

    function automatic logic word_aligned(input logic [1:0] lo);
        return lo == 2'b00;
    endfunction

endpackage

// File: rtl/inst_mem_pipe_if.sv
// Fetch request/response, flush and program-load signals between the IF
// stage (master) and the instruction memory (slave).
interface inst_mem_pipe_if
    import inst_mem_pipe_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int INST_W = INST_DATA_W
) ();

    // A transfer happens on a rising edge where valid && ready are both 1.
    // Once raised, rsp_valid and its payload stay put until rsp_ready is seen.
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [INST_W-1:0] rsp_inst;
    logic [ADDR_W-1:0] rsp_addr;
    logic              rsp_err;
    logic              flush;
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [INST_W-1:0] ld_data;

    modport master (
        output req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        input  req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready, flush, ld_en, ld_addr, ld_data,
        output req_ready, rsp_valid, rsp_inst, rsp_addr, rsp_err
    );

endinterface

// File: rtl/inst_mem_pipe_ram.sv
// Single-port instruction RAM: one write port and a registered read port
// that only updates on a read enable, so it doubles as a hold register.
module inst_mem_ram
    import inst_mem_pipe_pkg::*;
#(
    parameter int DEPTH = MEM_INST_SIZE,
    parameter int WIDTH = INST_DATA_W
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/inst_mem_pipe.sv
// Instruction memory with an RD_LAT-deep fetch pipe, flush for branch
// redirect, a program-load port and misaligned/out-of-range fault reporting.
module inst_mem_pipe
    import inst_mem_pipe_pkg::*;
#(
    parameter int                ADDR_W   = INST_ADDR_W,
    parameter int                INST_W   = INST_DATA_W,
    parameter int                DEPTH    = MEM_INST_SIZE,
    parameter int                RD_LAT   = 1,
    parameter logic [INST_W-1:0] NOP_INST = INST_W'(NOP_INST_DEF)
) (
    input logic            clk,
    input logic            rst_n,
    inst_mem_pipe_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    // Any byte-address bit at or above this mask lies past the last word.
    localparam logic [ADDR_W-1:0] HI_MASK = ~ADDR_W'(DEPTH * 4 - 1);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [ADDR_W-1:0] addr;
    } stage_t;

    stage_t            stg [1:RD_LAT];
    stage_t            tail;
    logic              advance;
    logic              accept;
    logic              req_fault;
    logic              ld_ok;
    logic              ram_we;
    logic              ram_en;
    logic [IDX_W-1:0]  ram_addr;
    logic [INST_W-1:0] ram_q;
    logic [INST_W-1:0] out_data;

    assign tail    = stg[RD_LAT];
    assign advance = !(tail.valid && !bus.rsp_ready);
    assign bus.req_ready = advance && !bus.ld_en && rst_n;
    assign accept  = bus.req_valid && bus.req_ready;

    assign req_fault = !word_aligned(bus.req_addr[1:0]) || (|(bus.req_addr & HI_MASK));
    assign ld_ok     = word_aligned(bus.ld_addr[1:0]) && !(|(bus.ld_addr & HI_MASK));

    // Load and fetch never share a cycle (ld_en drops req_ready), so one port suffices.
    assign ram_we   = bus.ld_en && ld_ok;
    assign ram_en   = accept;
    assign ram_addr = bus.ld_en ? bus.ld_addr[IDX_W+1:2] : bus.req_addr[IDX_W+1:2];

    inst_mem_ram #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (bus.ld_data),
        .rdata (ram_q)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 1; k <= RD_LAT; k++) begin
                stg[k] <= '0;
            end
        end else begin
            if (advance) begin
                stg[1] <= '{valid: accept, err: req_fault, addr: bus.req_addr};
                for (int k = 2; k <= RD_LAT; k++) begin
                    stg[k] <= stg[k-1];
                end
            end
            // A redirect kills everything older; the request taken this edge survives.
            if (bus.flush) begin
                for (int k = 2; k <= RD_LAT; k++) begin
                    stg[k].valid <= 1'b0;
                end
                stg[1].valid <= accept;
            end
        end
    end

    // Stage 1 data lives in the RAM read register; later stages carry copies.
    if (RD_LAT == 1) begin : g_lat1
        assign out_data = ram_q;
    end else begin : g_latn
        logic [INST_W-1:0] dly [1:RD_LAT-1];

        always_ff @(posedge clk) begin
            if (advance) begin
                dly[1] <= ram_q;
                for (int k = 2; k <= RD_LAT - 1; k++) begin
                    dly[k] <= dly[k-1];
                end
            end
        end

        assign out_data = dly[RD_LAT-1];
    end

    assign bus.rsp_valid = tail.valid;
    assign bus.rsp_err   = tail.valid && tail.err;
    assign bus.rsp_addr  = tail.valid ? tail.addr : '0;
    assign bus.rsp_inst  = !tail.valid ? '0 : (tail.err ? NOP_INST : out_data);

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Directed bench for inst_mem_pipe: three instances with RD_LAT 1..3 and a
// scoreboard queue of {err, addr, inst} checked as responses are taken.
module tb_inst_mem_pipe;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst_n;
    logic        req_valid [NDUT];
    logic [31:0] req_addr  [NDUT];
    logic        rsp_ready [NDUT];
    logic        flush     [NDUT];
    logic        ld_en     [NDUT];
    logic [31:0] ld_addr   [NDUT];
    logic [31:0] ld_data   [NDUT];
    logic        req_ready [NDUT];
    logic        rsp_valid [NDUT];
    logic [31:0] rsp_inst  [NDUT];
    logic [31:0] rsp_addr  [NDUT];
    logic        rsp_err   [NDUT];

    int          tests;
    int          fails;
    int          sel;
    logic [64:0] exp_q [$];
    logic [64:0] mon_exp;
    logic [64:0] mon_obs;
    logic [31:0] model [NDUT][1024];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        inst_mem_pipe_if #(.ADDR_W(32), .INST_W(32)) bus ();

        inst_mem_pipe #(
            .ADDR_W   (32),
            .INST_W   (32),
            .DEPTH    (1024),
            .RD_LAT   (g + 1),
            .NOP_INST (32'h0000_0013)
        ) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        assign bus.req_valid = req_valid[g];
        assign bus.req_addr  = req_addr[g];
        assign bus.rsp_ready = rsp_ready[g];
        assign bus.flush     = flush[g];
        assign bus.ld_en     = ld_en[g];
        assign bus.ld_addr   = ld_addr[g];
        assign bus.ld_data   = ld_data[g];
        assign req_ready[g]  = bus.req_ready;
        assign rsp_valid[g]  = bus.rsp_valid;
        assign rsp_inst[g]   = bus.rsp_inst;
        assign rsp_addr[g]   = bus.rsp_addr;
        assign rsp_err[g]    = bus.rsp_err;
    end

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [64:0] expect_of(input logic [31:0] a);
        if (a[1:0] != 2'b00 || a >= 32'h0000_1000) begin
            return {1'b1, a, 32'h0000_0013};
        end
        return {1'b0, a, model[sel][a[11:2]]};
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        ld_en[sel]   = 1'b1;
        ld_addr[sel] = a;
        ld_data[sel] = d;
        if (a[1:0] == 2'b00 && a < 32'h0000_1000) begin
            model[sel][a[11:2]] = d;
        end
        tick();
        ld_en[sel] = 1'b0;
    endtask

    task automatic issue(input logic [31:0] a);
        int n = 0;
        req_valid[sel] = 1'b1;
        req_addr[sel]  = a;
        #1;
        while (req_ready[sel] !== 1'b1 && n < 20) begin
            tick();
            #1;
            n++;
        end
        tests++;
        assert (req_ready[sel] === 1'b1) else begin
            fails++;
            $error("FAIL accept_%h: req_ready observed %b expected 1", a, req_ready[sel]);
        end
        if (req_ready[sel] === 1'b1) begin
            exp_q.push_back(expect_of(a));
        end
        tick();
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rsp_valid[sel] === 1'b1 && rsp_ready[sel] === 1'b1) begin
            mon_obs = {rsp_err[sel], rsp_addr[sel], rsp_inst[sel]};
            tests++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL unexpected_rsp: observed %h expected no response", mon_obs);
            end
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                tests++;
                assert (mon_obs === mon_exp) else begin
                    fails++;
                    $error("FAIL rsp: observed %h expected %h", mon_obs, mon_exp);
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        tests = 0;
        fails = 0;
        sel   = 0;
        rst_n = 1'b0;
        for (int g = 0; g < NDUT; g++) begin
            req_valid[g] = 1'b0;
            req_addr[g]  = '0;
            rsp_ready[g] = 1'b1;
            flush[g]     = 1'b0;
            ld_en[g]     = 1'b0;
            ld_addr[g]   = '0;
            ld_data[g]   = '0;
        end
        tick();
        tick();
        for (int g = 0; g < NDUT; g++) begin
            check($sformatf("rst_ready%0d", g), 65'(req_ready[g]), 65'(0));
            check($sformatf("rst_valid%0d", g), 65'(rsp_valid[g]), 65'(0));
            check($sformatf("rst_inst%0d", g), 65'(rsp_inst[g]), 65'(0));
            check($sformatf("rst_addr%0d", g), 65'(rsp_addr[g]), 65'(0));
            check($sformatf("rst_err%0d", g), 65'(rsp_err[g]), 65'(0));
        end
        rst_n = 1'b1;
        tick();

        // Back-to-back fetch, RD_LAT=2
        sel = 1;
        load(32'h0, 32'h11);
        load(32'h4, 32'h22);
        load(32'h8, 32'h33);
        load(32'hC, 32'h44);
        issue(32'h0);
        check("b2b_early", 65'(rsp_valid[1]), 65'(0));
        issue(32'h4);
        check("b2b_first_valid", 65'(rsp_valid[1]), 65'(1));
        check("b2b_first_inst", 65'(rsp_inst[1]), 65'(32'h11));
        issue(32'h8);
        issue(32'hC);
        req_valid[1] = 1'b0;
        tick();
        tick();
        check("b2b_drained", 65'(exp_q.size()), 65'(0));
        check("b2b_idle", 65'(rsp_valid[1]), 65'(0));

        // Backpressure, RD_LAT=1; also ignored misaligned / out-of-range loads
        sel = 0;
        load(32'h0, 32'hA0);
        load(32'h4, 32'hB0);
        load(32'h6, 32'hBAD0);
        load(32'h1004, 32'hBAD1);
        rsp_ready[0] = 1'b0;
        issue(32'h0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 32'h4;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall_valid%0d", i), 65'(rsp_valid[0]), 65'(1));
            check($sformatf("stall_inst%0d", i), 65'(rsp_inst[0]), 65'(32'hA0));
            check($sformatf("stall_addr%0d", i), 65'(rsp_addr[0]), 65'(0));
            check($sformatf("stall_ready%0d", i), 65'(req_ready[0]), 65'(0));
            tick();
            #1;
        end
        rsp_ready[0] = 1'b1;
        #1;
        check("stall_release_ready", 65'(req_ready[0]), 65'(1));
        exp_q.push_back(expect_of(32'h4));
        tick();
        req_valid[0] = 1'b0;
        check("stall_next_inst", 65'(rsp_inst[0]), 65'(32'hB0));
        tick();
        check("stall_drained", 65'(exp_q.size()), 65'(0));

        // Faults and last valid word, DEPTH=1024
        load(32'hFFC, 32'h55);
        issue(32'h2);
        check("fault_mis_err", 65'(rsp_err[0]), 65'(1));
        check("fault_mis_inst", 65'(rsp_inst[0]), 65'(32'h13));
        issue(32'h1000);
        check("fault_range_addr", 65'(rsp_addr[0]), 65'(32'h1000));
        issue(32'hFFC);
        req_valid[0] = 1'b0;
        tick();
        tick();
        check("fault_drained", 65'(exp_q.size()), 65'(0));

        // Flush with a redirect request, RD_LAT=3
        sel = 2;
        load(32'h0, 32'hC0);
        load(32'h4, 32'hC4);
        load(32'h40, 32'hC40);
        issue(32'h0);
        issue(32'h4);
        req_valid[2] = 1'b1;
        req_addr[2]  = 32'h40;
        flush[2]     = 1'b1;
        #1;
        check("flush_ready", 65'(req_ready[2]), 65'(1));
        exp_q.delete();
        exp_q.push_back(expect_of(32'h40));
        tick();
        flush[2]     = 1'b0;
        req_valid[2] = 1'b0;
        check("flush_gap0", 65'(rsp_valid[2]), 65'(0));
        tick();
        check("flush_gap1", 65'(rsp_valid[2]), 65'(0));
        tick();
        check("flush_hit_valid", 65'(rsp_valid[2]), 65'(1));
        check("flush_hit_addr", 65'(rsp_addr[2]), 65'(32'h40));
        check("flush_hit_inst", 65'(rsp_inst[2]), 65'(32'hC40));
        tick();
        tick();
        check("flush_drained", 65'(exp_q.size()), 65'(0));
        check("flush_idle", 65'(rsp_valid[2]), 65'(0));

        // Load priority over a held request, RD_LAT=2
        sel = 1;
        req_valid[1] = 1'b1;
        req_addr[1]  = 32'h8;
        ld_en[1]     = 1'b1;
        ld_addr[1]   = 32'h8;
        ld_data[1]   = 32'hDEAD_BEEF;
        model[1][2]  = 32'hDEAD_BEEF;
        #1;
        check("ld_prio_ready", 65'(req_ready[1]), 65'(0));
        tick();
        ld_en[1] = 1'b0;
        issue(32'h8);
        req_valid[1] = 1'b0;
        tick();
        check("ld_new_data", 65'(rsp_inst[1]), 65'(32'hDEAD_BEEF));
        tick();
        check("ld_drained", 65'(exp_q.size()), 65'(0));

        // Reset with two fetches in flight, RD_LAT=2
        rsp_ready[1] = 1'b0;
        issue(32'h0);
        issue(32'h4);
        req_valid[1] = 1'b0;
        check("rst_mid_pending", 65'(rsp_valid[1]), 65'(1));
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        check("rst_mid_valid", 65'(rsp_valid[1]), 65'(0));
        check("rst_mid_inst", 65'(rsp_inst[1]), 65'(0));
        rsp_ready[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        check("rst_mid_quiet", 65'(rsp_valid[1]), 65'(0));

        check("final_queue", 65'(exp_q.size()), 65'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_pipe.md
Name: inst_mem_pipe

Overview:
Parametrised instruction memory for the pipelined core. It replaces the combinational single-cycle fetch array with a synchronous-read RAM and a valid/ready fetch request/response interface. Read latency is configurable. The block adds a flush port for branch redirect, a program-load write port, and fault reporting for misaligned or out-of-range fetches. It sits between the IF stage and the instruction storage.

Parameters:
ADDR_W, 32, byte-address width of req_addr and ld_addr.
INST_W, 32, instruction word width.
DEPTH, 1024, number of INST_W words; must be a power of 2.
RD_LAT, 1, cycles from request acceptance to rsp_valid; legal range 1..4.
NOP_INST, 32'h0000_0013, word returned on a faulted fetch (addi x0,x0,0).

Ports:
clk  in  1  core clock; all state updates on its rising edge.
rst_n  in  1  reset, synchronous, active-low.
req_valid  in  1  fetch request valid.
req_ready  out  1  fetch request accepted when req_valid && req_ready.
req_addr  in  ADDR_W  fetch byte address (PC).
rsp_valid  out  1  response valid.
rsp_ready  in  1  consumer accepts the response.
rsp_inst  out  INST_W  fetched instruction.
rsp_addr  out  ADDR_W  PC of the returned instruction.
rsp_err  out  1  fetch fault: misaligned or out of range.
flush  in  1  discard all in-flight fetches.
ld_en  in  1  program-load word write.
ld_addr  in  ADDR_W  load byte address; word-aligned.
ld_data  in  INST_W  load data.

Behaviour:
- Clock and reset: clk, with rst_n synchronous active-low.
- Reset: on a rising edge with rst_n=0:
  - all stage valids clear, so rsp_valid=0;
  - rsp_inst, rsp_addr and rsp_err hold 0;
  - req_ready=0 during the reset cycle.
  - RAM contents are not reset.
- Word index: req_addr[log2(DEPTH)+1:2].
- Fault conditions:
  - misaligned: req_addr[1:0]!=0;
  - out of range: any req_addr bit above log2(DEPTH)+1 is set.
  - A faulted fetch still occupies the pipe. It returns rsp_err=1, rsp_inst=NOP_INST, and rsp_addr=req_addr.
- Pipeline structure: RD_LAT stages, each holding {valid, addr, err}. Stage 1 is loaded from the synchronous RAM read at the acceptance edge.
- Advance rule: advance = !(stage[RD_LAT].valid && !rsp_ready). The whole pipe shifts only when advance=1.
- Ready rule: req_ready = advance && !ld_en && rst_n.
- Latency: with no stall, a request accepted at edge N gives rsp_valid=1 in the cycle after edge N+RD_LAT-1. With RD_LAT=1, rsp_valid rises right after the acceptance edge. Throughput is one fetch per cycle.
- Backpressure: while rsp_valid && !rsp_ready, all outputs hold stable and no stage moves. Holding outputs stable needs an output data register, not a RAM re-read.
- Flush:
  - flush=1 clears every stage valid at the edge.
  - A request with req_valid=1 in the same cycle is still accepted and enters stage 1 with valid=1; it carries the redirected PC.
  - Flush during a stall also drops the stalled response. rsp_valid=0 next cycle unless the new request made it through (RD_LAT=1 only).
- Load port:
  - ld_en has priority over fetch; req_ready=0 while ld_en=1.
  - The write lands at word ld_addr[log2(DEPTH)+1:2] at the edge.
  - Out-of-range or misaligned ld_addr is ignored (no write).
  - In-flight fetches keep the data they already captured.
  - A fetch accepted the cycle after a load sees the new data; no bypass is needed.
- Simultaneous events: reset beats flush, flush beats the stall hold, and ld_en beats a request.
- Reset mid-operation discards all in-flight responses; none is returned after reset.

Decomposition:
- Shared package additions (define_core.v):
  - `NopInst;
  - `InstAddrBus / `InstBus derived from ADDR_W / INST_W defaults;
  - `mem_inst_size as the default DEPTH.
- One sub-module: inst_mem_ram, a single-port synchronous RAM with one write port and one registered read port, holding DEPTH×INST_W words.
- Pipeline control, fault detection and output holding stay in inst_mem_pipe.

Test Plan:
- Back-to-back fetch, RD_LAT=2:
  - Stimulus: preload words 0..3 = 0x11,0x22,0x33,0x44; request 0x0,0x4,0x8,0xC on consecutive cycles with rsp_ready=1.
  - Required: rsp_inst 0x11,0x22,0x33,0x44 on consecutive cycles, the first 2 cycles after the first acceptance; rsp_err=0.
- Backpressure:
  - Stimulus: RD_LAT=1; hold rsp_ready=0 for 3 cycles with a response pending.
  - Required: rsp_valid=1, with rsp_inst/rsp_addr unchanged for all 3 cycles; req_ready=0; the next response follows after rsp_ready=1.
- Faults:
  - Stimulus: request 0x2, then 0x1000 with DEPTH=1024.
  - Required: both return rsp_err=1, rsp_inst=0x00000013, and rsp_addr equal to the request.
- Flush:
  - Stimulus: RD_LAT=3; issue 0x0,0x4; assert flush together with a request to 0x40.
  - Required: only 0x40 is returned, 3 cycles later; 0x0 and 0x4 are never output.
- Load priority:
  - Stimulus: ld_en with ld_addr=0x8, ld_data=0xDEADBEEF, while req_valid is held.
  - Required: req_ready=0 that cycle; the next fetch of 0x8 returns 0xDEADBEEF.
- Reset mid-flight:
  - Stimulus: deassert rst_n for one cycle with 2 fetches in flight.
  - Required: rsp_valid=0 the cycle after reset; no stale responses appear afterwards.
